// File: rtl/sort_frame_scheduler_pkg.sv
// Shared types for the sort frame scheduler.
// NETWORK_WIDTH / INDEX_WIDTH are the widths shared with the bitonic sort network.
// The frame typedefs describe a frame at the default network size.
package sort_frame_scheduler_pkg;

   localparam int NETWORK_WIDTH = 16;
   localparam int INDEX_WIDTH   = 4;
   localparam int DEFAULT_SIZE  = 8;

   typedef logic [NETWORK_WIDTH-1:0] sample_t;
   typedef logic [INDEX_WIDTH-1:0]   index_t;

   typedef sample_t [DEFAULT_SIZE-1:0] frame_data_t;
   typedef index_t  [DEFAULT_SIZE-1:0] frame_index_t;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/sort_frame_scheduler_if.sv
// Sample-in / sorted-pair-out stream bundle of the sort frame scheduler.
//   in_valid/in_ready/in_data           : serial sample stream into the scheduler
//   out_valid/out_ready/out_data/
//   out_index/out_last                  : sorted (value, arrival index) stream out
// master = scheduler side, slave = surrounding logic (front end + decision logic).
interface sort_frame_scheduler_if;
   import sort_frame_scheduler_pkg::*;

   logic    in_valid;
   logic    in_ready;
   sample_t in_data;
   logic    out_valid;
   logic    out_ready;
   sample_t out_data;
   index_t  out_index;
   logic    out_last;

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );

endinterface

// File: rtl/sort_frame_buffer.sv
// SIZE-entry capture register for one frame. Each write lands in the slot
// selected by the fill counter and records that counter as the arrival tag.
// Ports:
//   clk, reset  : clock, synchronous active-low reset (clears counter and slots)
//   wr_en       : accept wr_data into the next slot
//   wr_data     : sample to store
//   slots, tags : frame contents and their arrival indices
//   last_slot   : this write fills slot SIZE-1 (counter wraps to 0)
module sort_frame_buffer
   import sort_frame_scheduler_pkg::*;
#(
   parameter int SIZE = 8
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  sample_t             wr_data,
   output sample_t [SIZE-1:0]  slots,
   output index_t  [SIZE-1:0]  tags,
   output logic                last_slot
);

   localparam int CNT_W = $clog2(SIZE);

   logic [CNT_W-1:0] fill_count;

   assign last_slot = wr_en && (fill_count == CNT_W'(SIZE - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         fill_count <= '0;
         slots      <= '0;
         tags       <= '0;
      end else if (wr_en) begin
         slots[fill_count] <= wr_data;
         tags[fill_count]  <= index_t'(fill_count);
         // SIZE is a power of two, so the counter wraps to 0 after the last slot.
         fill_count        <= fill_count + 1'b1;
      end
   end

endmodule

// File: rtl/sort_frame_scheduler.sv
// Sequences an external registered bitonic sort network over a sample stream:
// gathers SIZE samples with arrival tags, clears the network, launches it,
// waits for its sticky done (bounded by TIMEOUT) and drains the OUT_COUNT
// largest (value, index) pairs, largest first.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   bus               : sample input and sorted-pair output streams
//   busy              : high in any state other than FILL
//   err_timeout       : one-cycle pulse when a sort is abandoned
//   sorter_reset      : active-high network reset (reset asserted or CLEAR)
//   sorter_ready      : network launch level, held for the whole WAIT
//   sorter_data/index : frame and tags presented to the network
//   sorter_data_out/
//   sorter_index_out  : network result, ascending
//   sorter_done       : network done, sticky until its reset
module sort_frame_scheduler
   import sort_frame_scheduler_pkg::*;
#(
   parameter int SIZE      = 8,
   parameter int OUT_COUNT = 4,
   parameter int TIMEOUT   = 255
)(
   input  logic                          clk,
   input  logic                          reset,
   sort_frame_scheduler_if.master        bus,
   output logic                          busy,
   output logic                          err_timeout,
   output logic                          sorter_reset,
   output logic                          sorter_ready,
   output logic [SIZE*NETWORK_WIDTH-1:0] sorter_data,
   output logic [SIZE*INDEX_WIDTH-1:0]   sorter_index,
   input  logic [SIZE*NETWORK_WIDTH-1:0] sorter_data_out,
   input  logic [SIZE*INDEX_WIDTH-1:0]   sorter_index_out,
   input  logic                          sorter_done
);

   localparam int CNT_W  = $clog2(SIZE);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_size_chk
      $error("SIZE must be a power of two >= 2");
   end
   if (OUT_COUNT < 1 || OUT_COUNT > SIZE) begin : g_out_chk
      $error("OUT_COUNT must be in 1..SIZE");
   end
   if (INDEX_WIDTH < CNT_W) begin : g_idx_chk
      $error("INDEX_WIDTH must be at least log2(SIZE)");
   end

   state_t              state;
   logic                in_ready_r;
   logic                out_valid_r;
   logic [CNT_W-1:0]    drain_count;
   logic [CNT_W-1:0]    drain_pos;
   logic [TCNT_W-1:0]   tcnt;
   logic [TCNT_W-1:0]   tcnt_inc;
   sample_t [SIZE-1:0]  res_data;
   index_t  [SIZE-1:0]  res_index;
   sample_t [SIZE-1:0]  slots;
   index_t  [SIZE-1:0]  tags;
   logic                accept;
   logic                last_slot;
   logic                last_pair;
   logic                drain_hs;

   // in_ready_r is only ever high in FILL, so it doubles as the state qualifier.
   assign accept   = bus.in_valid & in_ready_r;
   assign drain_hs = out_valid_r & bus.out_ready;

   sort_frame_buffer #(
      .SIZE (SIZE)
   ) u_buffer (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (accept),
      .wr_data   (bus.in_data),
      .slots     (slots),
      .tags      (tags),
      .last_slot (last_slot)
   );

   assign sorter_data  = slots;
   assign sorter_index = tags;
   assign sorter_reset = ~reset | (state == ST_CLEAR);

   // Ascending network: pair k comes from result position SIZE-1-k.
   assign drain_pos     = CNT_W'(SIZE - 1) - drain_count;
   assign last_pair     = (drain_count == CNT_W'(OUT_COUNT - 1));
   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = res_data[drain_pos];
   assign bus.out_index = res_index[drain_pos];
   assign bus.out_last  = out_valid_r & last_pair;

   // Saturating so the counter can never wrap even if the compare is missed.
   assign tcnt_inc = (tcnt == TCNT_W'(TIMEOUT)) ? tcnt : tcnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_FILL;
         in_ready_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         busy         <= 1'b0;
         err_timeout  <= 1'b0;
         sorter_ready <= 1'b0;
         drain_count  <= '0;
         tcnt         <= '0;
         res_data     <= '0;
         res_index    <= '0;
      end else begin
         err_timeout <= 1'b0;
         case (state)
            ST_FILL: begin
               in_ready_r <= 1'b1;
               if (accept && last_slot) begin
                  state      <= ST_CLEAR;
                  in_ready_r <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            // One cycle of sorter_reset drops the network's sticky done
            // and latched ready from the previous frame.
            ST_CLEAR: begin
               state        <= ST_WAIT;
               sorter_ready <= 1'b1;
               tcnt         <= '0;
            end
            // Done is checked first so it wins over a same-cycle expiry.
            ST_WAIT: begin
               if (sorter_done) begin
                  res_data     <= sorter_data_out;
                  res_index    <= sorter_index_out;
                  tcnt         <= '0;
                  state        <= ST_DRAIN;
                  sorter_ready <= 1'b0;
                  out_valid_r  <= 1'b1;
                  drain_count  <= '0;
               end else if (tcnt_inc == TCNT_W'(TIMEOUT)) begin
                  err_timeout  <= 1'b1;
                  tcnt         <= '0;
                  state        <= ST_FILL;
                  sorter_ready <= 1'b0;
                  busy         <= 1'b0;
                  in_ready_r   <= 1'b1;
               end else begin
                  tcnt <= tcnt_inc;
               end
            end
            ST_DRAIN: begin
               if (drain_hs) begin
                  if (last_pair) begin
                     out_valid_r <= 1'b0;
                     drain_count <= '0;
                     state       <= ST_FILL;
                     busy        <= 1'b0;
                     in_ready_r  <= 1'b1;
                  end else begin
                     drain_count <= drain_count + 1'b1;
                  end
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sort_frame_scheduler.sv
module tb_sort_frame_scheduler;
   import sort_frame_scheduler_pkg::*;

   localparam int N = 8;

   localparam logic [127:0] FRAME1 = {16'd1, 16'd44, 16'd3, 16'd90, 16'd7, 16'd12, 16'd90, 16'd5};
   localparam logic [127:0] FRAME2 = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd300, 16'd2, 16'd100};
   localparam logic [127:0] FRAME3 = {16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
   localparam logic [127:0] FRAME4 = {16'd88, 16'd77, 16'd66, 16'd55, 16'd44, 16'd33, 16'd22, 16'd11};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                          busy, err_timeout, sorter_reset, sorter_ready, sorter_done;
   logic [N*NETWORK_WIDTH-1:0]    sorter_data, sorter_data_out;
   logic [N*INDEX_WIDTH-1:0]      sorter_index, sorter_index_out;

   sort_frame_scheduler_if bus ();

   sort_frame_scheduler #(.SIZE(8), .OUT_COUNT(4), .TIMEOUT(20)) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .busy             (busy),
      .err_timeout      (err_timeout),
      .sorter_reset     (sorter_reset),
      .sorter_ready     (sorter_ready),
      .sorter_data      (sorter_data),
      .sorter_index     (sorter_index),
      .sorter_data_out  (sorter_data_out),
      .sorter_index_out (sorter_index_out),
      .sorter_done      (sorter_done)
   );

   // Behavioural sort network: ascending, stable, done sticky until sorter_reset.
   logic        model_hang = 1'b0;
   logic        m_done;
   int          m_cnt;
   logic [15:0] sd [N];
   logic [3:0]  si [N];
   logic [15:0] td;
   logic [3:0]  ti;

   always_comb begin
      td = '0;
      ti = '0;
      for (int i = 0; i < N; i++) begin
         sd[i] = sorter_data[i*16 +: 16];
         si[i] = sorter_index[i*4 +: 4];
      end
      for (int p = 0; p < N - 1; p++) begin
         for (int j = 0; j < N - 1 - p; j++) begin
            if (sd[j] > sd[j+1]) begin
               td = sd[j]; sd[j] = sd[j+1]; sd[j+1] = td;
               ti = si[j]; si[j] = si[j+1]; si[j+1] = ti;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (sorter_reset) begin
         m_done           <= 1'b0;
         m_cnt            <= 0;
         sorter_data_out  <= '0;
         sorter_index_out <= '0;
      end else if (sorter_ready && !m_done && !model_hang) begin
         if (m_cnt == 5) begin
            m_done <= 1'b1;
            for (int i = 0; i < N; i++) begin
               sorter_data_out[i*16 +: 16] <= sd[i];
               sorter_index_out[i*4 +: 4]  <= si[i];
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end
   assign sorter_done = m_done;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] cap_d [4];
   logic [3:0]  cap_i [4];
   logic        cap_l [4];
   logic        cap_lat_ok;

   task automatic feed(input logic [127:0] vals, input int gap);
      int n;
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = vals[i*16 +: 16];
         n = 0;
         while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n == 50) begin
            checks++; failures++;
            $display("FAIL feed_wait sample %0d: in_ready=%b required 1 within 50 cycles", i, bus.in_ready);
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic capture();
      int   n = 0;
      int   k = 0;
      logic dprev = 1'b0;
      cap_lat_ok    = 1'b0;
      bus.out_ready = 1'b1;
      while (k < 4 && n < 100) begin
         @(negedge clk);
         n++;
         if (bus.out_valid === 1'b1) begin
            if (k == 0) cap_lat_ok = dprev;
            cap_d[k] = bus.out_data;
            cap_i[k] = bus.out_index;
            cap_l[k] = bus.out_last;
            k++;
         end
         dprev = sorter_done;
      end
      if (k < 4) begin
         checks++; failures++;
         $display("FAIL capture_wait: got %0d pairs required 4", k);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
      checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b required 0", bus.out_last); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", err_timeout); end
      checks++; if (sorter_ready !== 1'b0) begin failures++; $display("FAIL reset_sorter_ready: got %b required 0", sorter_ready); end
      checks++; if (sorter_reset !== 1'b1) begin failures++; $display("FAIL reset_sorter_reset: got %b required 1", sorter_reset); end
      checks++; if (sorter_data !== '0) begin failures++; $display("FAIL reset_frame: got %h required 0", sorter_data); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (sorter_reset !== 1'b0) begin failures++; $display("FAIL fill_sorter_reset: got %b required 0", sorter_reset); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL fill_in_ready: got %b required 1", bus.in_ready); end
   endtask

   task automatic test_basic_sort();
      feed(FRAME1, 0);
      checks++; if (sorter_reset !== 1'b1) begin failures++; $display("FAIL clear_sorter_reset: got %b required 1", sorter_reset); end
      checks++; if (sorter_ready !== 1'b0) begin failures++; $display("FAIL clear_sorter_ready: got %b required 0", sorter_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy: got %b required 1", busy); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL clear_in_ready: got %b required 0", bus.in_ready); end
      @(negedge clk);
      checks++; if (sorter_reset !== 1'b0) begin failures++; $display("FAIL wait_sorter_reset: got %b required 0", sorter_reset); end
      checks++; if (sorter_ready !== 1'b1) begin failures++; $display("FAIL wait_sorter_ready: got %b required 1", sorter_ready); end
      capture();
      checks++; if (cap_lat_ok !== 1'b1) begin failures++; $display("FAIL done_latency: done-before-first-valid=%b required 1", cap_lat_ok); end
      checks++;
      if (cap_d[0] !== 16'd90 || cap_d[1] !== 16'd90 ||
          !((cap_i[0] === 4'd1 && cap_i[1] === 4'd4) || (cap_i[0] === 4'd4 && cap_i[1] === 4'd1))) begin
         failures++;
         $display("FAIL basic_pair01: got (%0d,%0d)(%0d,%0d) required (90,1|4)(90,4|1)", cap_d[0], cap_i[0], cap_d[1], cap_i[1]);
      end
      checks++; if (cap_d[2] !== 16'd44 || cap_i[2] !== 4'd6) begin failures++; $display("FAIL basic_pair2: got (%0d,%0d) required (44,6)", cap_d[2], cap_i[2]); end
      checks++; if (cap_d[3] !== 16'd12 || cap_i[3] !== 4'd2) begin failures++; $display("FAIL basic_pair3: got (%0d,%0d) required (12,2)", cap_d[3], cap_i[3]); end
      checks++;
      if (cap_l[0] !== 1'b0 || cap_l[1] !== 1'b0 || cap_l[2] !== 1'b0 || cap_l[3] !== 1'b1) begin
         failures++;
         $display("FAIL basic_last: got %b%b%b%b required 0001", cap_l[0], cap_l[1], cap_l[2], cap_l[3]);
      end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_after_valid: got %b required 0", bus.out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_after_busy: got %b required 0", busy); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_after_in_ready: got %b required 1", bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ed [4] = '{16'd300, 16'd100, 16'd8, 16'd7};
      logic [3:0]  ei [4] = '{4'd2, 4'd0, 4'd7, 4'd6};
      feed(FRAME2, 0);
      capture();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap_d[k] !== ed[k] || cap_i[k] !== ei[k]) begin
            failures++;
            $display("FAIL b2b_pair%0d: got (%0d,%0d) required (%0d,%0d)", k, cap_d[k], cap_i[k], ed[k], ei[k]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_drain_stall();
      logic [15:0] ed [4] = '{16'd9, 16'd8, 16'd7, 16'd6};
      logic [3:0]  ei [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      int          pat [4] = '{1, 0, 0, 1};
      int          n = 0;
      int          hs = 0;
      int          vcyc = 0;
      bus.out_ready = 1'b0;
      feed(FRAME3, 0);
      while (hs < 4 && n < 100) begin
         @(negedge clk);
         n++;
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (bus.out_data !== ed[hs] || bus.out_index !== ei[hs] || bus.out_last !== (hs == 3)) begin
               failures++;
               $display("FAIL stall_pair%0d cyc%0d: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                        hs, vcyc, bus.out_data, bus.out_index, bus.out_last, ed[hs], ei[hs], (hs == 3));
            end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc%0d: got %b required 0", vcyc, bus.in_ready); end
            bus.out_ready = (vcyc < 4) ? (pat[vcyc] != 0) : 1'b1;
            if (bus.out_ready) hs++;
            vcyc++;
         end
      end
      @(negedge clk);
      checks++; if (vcyc != 6) begin failures++; $display("FAIL stall_valid_cycles: got %0d required 6", vcyc); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_after_valid: got %b required 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stall_after_in_ready: got %b required 1", bus.in_ready); end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_timeout();
      int   err_at = -1;
      int   pulses = 0;
      logic ir_after = 1'b0;
      logic saw_valid = 1'b0;
      model_hang = 1'b1;
      feed(FRAME1, 0);
      @(negedge clk);
      checks++; if (sorter_ready !== 1'b1) begin failures++; $display("FAIL to_sorter_ready: got %b required 1", sorter_ready); end
      for (int c = 0; c < 40; c++) begin
         if (err_at >= 0 && c == err_at + 1) ir_after = bus.in_ready;
         if (err_timeout === 1'b1) begin
            pulses++;
            if (err_at < 0) err_at = c;
         end
         if (bus.out_valid === 1'b1) saw_valid = 1'b1;
         @(negedge clk);
      end
      checks++; if (err_at != 20) begin failures++; $display("FAIL to_err_cycle: got %0d required 20", err_at); end
      checks++; if (pulses != 1) begin failures++; $display("FAIL to_err_pulses: got %0d required 1", pulses); end
      checks++; if (ir_after !== 1'b1) begin failures++; $display("FAIL to_in_ready: got %b required 1", ir_after); end
      checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL to_out_valid: got %b required 0", saw_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy: got %b required 0", busy); end
      model_hang = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] ed [4] = '{16'd9, 16'd8, 16'd7, 16'd6};
      logic [3:0]  ei [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      int          n;
      // reset during WAIT
      model_hang = 1'b1;
      feed(FRAME1, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || sorter_reset !== 1'b1 || busy !== 1'b0 || sorter_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_wait: got valid=%b sreset=%b busy=%b sready=%b required 0 1 0 0", bus.out_valid, sorter_reset, busy, sorter_ready);
      end
      reset = 1'b1;
      model_hang = 1'b0;
      // reset during DRAIN
      bus.out_ready = 1'b0;
      feed(FRAME2, 0);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_drain_reach: got %b required 1", bus.out_valid); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || sorter_reset !== 1'b1 || busy !== 1'b0 || bus.out_last !== 1'b0) begin
         failures++;
         $display("FAIL rst_drain: got valid=%b sreset=%b busy=%b last=%b required 0 1 0 0", bus.out_valid, sorter_reset, busy, bus.out_last);
      end
      reset = 1'b1;
      bus.out_ready = 1'b1;
      // reset part-way through FILL discards the partial frame
      bus.in_valid = 1'b1;
      bus.in_data  = 16'd1000;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      feed(FRAME3, 0);
      capture();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap_d[k] !== ed[k] || cap_i[k] !== ei[k]) begin
            failures++;
            $display("FAIL rst_recover_pair%0d: got (%0d,%0d) required (%0d,%0d)", k, cap_d[k], cap_i[k], ed[k], ei[k]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_gapped();
      logic [15:0] ed [4] = '{16'd88, 16'd77, 16'd66, 16'd55};
      logic [3:0]  ei [4] = '{4'd7, 4'd6, 4'd5, 4'd4};
      logic        spurious = 1'b0;
      int          n;
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = FRAME4[i*16 +: 16];
         n = 0;
         while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            if (sorter_ready !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (i < N - 1) begin
            if (sorter_ready !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
            repeat (2) begin
               @(negedge clk);
               if (sorter_ready !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
            end
         end
      end
      checks++; if (spurious !== 1'b0) begin failures++; $display("FAIL gap_spurious_launch: got %b required 0", spurious); end
      @(negedge clk);
      checks++; if (sorter_index !== 32'h7654_3210) begin failures++; $display("FAIL gap_tags: got %h required 76543210", sorter_index); end
      checks++; if (sorter_data !== FRAME4) begin failures++; $display("FAIL gap_frame: got %h required %h", sorter_data, FRAME4); end
      capture();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cap_d[k] !== ed[k] || cap_i[k] !== ei[k]) begin
            failures++;
            $display("FAIL gap_pair%0d: got (%0d,%0d) required (%0d,%0d)", k, cap_d[k], cap_i[k], ed[k], ei[k]);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_sort();
      test_back_to_back();
      test_drain_stall();
      test_timeout();
      test_reset_mid();
      test_gapped();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sort_frame_scheduler.md
Name: sort_frame_scheduler

Overview:
- Sequences one registered bitonic sort network instance (SIZE inputs, ready/done handshake, sticky done) across a stream of samples.
- Gathers SIZE serial samples into a frame and tags each with its arrival index.
- Clears the network, launches the sort and waits for done, then drains the top OUT_COUNT (data, index) pairs as a stream.
- Sits between the sample front end and the peak/symbol-decision logic.

Parameters:
- SIZE, 8, sort network width; power of two, ≥2; must equal the network's SIZE.
- OUT_COUNT, 4, pairs emitted per frame; 1..SIZE.
- TIMEOUT, 255, max cycles in WAIT before abort; ≥ 2*log2(SIZE)^2 + 4.
- NETWORK_WIDTH / INDEX_WIDTH come from the shared parameter header, not module parameters. Require INDEX_WIDTH ≥ log2(SIZE).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  input sample valid.
- in_ready  out  1  scheduler accepts sample.
- in_data  in  NETWORK_WIDTH  sample.
- out_valid  out  1  sorted pair valid.
- out_ready  in  1  downstream accepts pair.
- out_data  out  NETWORK_WIDTH  sorted value.
- out_index  out  INDEX_WIDTH  arrival index of that value.
- out_last  out  1  final pair of frame.
- busy  out  1  high in any state other than FILL.
- err_timeout  out  1  one-cycle pulse on abort.
- sorter_reset  out  1  active-high reset to network.
- sorter_ready  out  1  network launch.
- sorter_data  out  SIZE*NETWORK_WIDTH  frame to network.
- sorter_index  out  SIZE*INDEX_WIDTH  tags to network.
- sorter_data_out  in  SIZE*NETWORK_WIDTH  network result.
- sorter_index_out  in  SIZE*INDEX_WIDTH  network result tags.
- sorter_done  in  1  network done (sticky until its reset).

Behaviour:
- Reset (reset=0):
  - State FILL; fill count 0; drain count 0; timeout counter 0.
  - Frame and result buffers 0.
  - in_ready=0 during reset; out_valid=0, out_last=0, busy=0, err_timeout=0, sorter_ready=0.
  - sorter_reset=1 combinationally while reset=0 (sorter_reset = ~reset | clear_state).
  - Reset mid-frame discards all data.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready: slot[fill_count] ← in_data, tag[fill_count] ← fill_count (zero-extended to INDEX_WIDTH), fill_count++.
  - Accepting slot SIZE-1 → CLEAR next cycle and fill_count ← 0.
- CLEAR:
  - Exactly 1 cycle; sorter_reset=1, sorter_ready=0, in_ready=0.
  - Clears the network's sticky done and latched ready. → LAUNCH.
- LAUNCH/WAIT (one state, WAIT):
  - sorter_ready=1 held continuously (network treats ready as level); sorter_data/index driven from buffers, stable.
  - Timeout counter increments each WAIT cycle.
  - sorter_done=1 → capture sorter_data_out/sorter_index_out into result buffer, counter ← 0, → DRAIN.
  - Counter reaches TIMEOUT without done → err_timeout pulse, frame dropped, → FILL.
  - done and expiry in the same cycle: done wins, no error.
- DRAIN:
  - sorter_ready=0.
  - out_valid=1; pair k (k=0..OUT_COUNT-1) = result position SIZE-1-k, i.e. largest first for an ascending network.
  - Advance on out_valid&out_ready only; out_data/out_index stable while stalled.
  - out_last=1 on k=OUT_COUNT-1; its acceptance → FILL.
  - No input accepted during DRAIN; in_ready=0.
- Latency:
  - Last input accept → sorter_ready rise: 2 cycles (FILL→CLEAR→WAIT).
  - sorter_done → first out_valid: 1 cycle.
- Width rules:
  - fill/drain counters log2(SIZE) bits.
  - Timeout counter clog2(TIMEOUT+1) bits; saturating, never wraps.
- Stalling: in_valid low during FILL stalls indefinitely with no timeout. Downstream stall in DRAIN is unbounded.

Decomposition:
- Shared package holds:
  - State enum (FILL, CLEAR, WAIT, DRAIN).
  - sample_t / index_t typedefs built from NETWORK_WIDTH / INDEX_WIDTH.
  - Frame array typedefs.
- Natural sub-module: sort_frame_buffer, the SIZE-entry write-indexed capture register with tag generation.
- FSM and drain mux stay in the top.

Test Plan:
- SIZE=8, OUT_COUNT=4, NETWORK_WIDTH=16, inputs 5,90,12,7,90,3,44,1 streamed back-to-back, out_ready=1 → outputs (90,4 or 1),(90,1 or 4),(44,6),(12,2); out_last on the 4th pair; busy low after.
- Reset sequencing → sorter_reset high exactly one cycle after the 8th accept; sorter_ready high from the next cycle until done; a second frame sorts correctly, proving sticky done was cleared.
- out_ready toggled 1,0,0,1 during DRAIN → each pair held stable while stalled; exactly 4 handshakes; in_ready stays 0 until the last accept.
- Network model never asserts done, TIMEOUT=20 → err_timeout pulses once, 20 cycles after WAIT entry; in_ready returns high next cycle; no out_valid.
- reset=0 asserted mid-WAIT and mid-DRAIN → next cycle out_valid=0, sorter_reset=1, state FILL, fill_count 0; a subsequent full frame gives correct output.
- in_valid gapped (1 sample every 3 cycles) → no spurious launch before the 8th sample; tags 0..7 match arrival order.
